bus_demux2: RTL

BUS_DEMUX2 -- requirements
Module: bus_demux2

---
 rtl/mips_bus_pkg.sv | 28 ++
 rtl/mux2.sv | 21 ++
 rtl/bus_demux2.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the two-port bus demultiplexer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   state_t           - request FSM encoding (IDLE / REQ / WAIT)
//   SEL_MASK_DEFAULT  - address bits compared for port selection
//   SEL_MATCH_DEFAULT - masked address value that selects the MMIO port
//   addr_is_mmio()    - port-select decode used on request acceptance
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [31:0] SEL_MASK_DEFAULT  = 32'hFFFF_0000;
  localparam logic [31:0] SEL_MATCH_DEFAULT = 32'hBFD0_0000;

  // 1 = address belongs to the MMIO target (port 1), 0 = data memory (port 0).
  function automatic logic addr_is_mmio(input logic [31:0] addr,
                                        input logic [31:0] mask,
                                        input logic [31:0] match);
    return (addr & mask) == match;
  endfunction

endpackage

// File: rtl/mux2.sv
// Generic two-input N-bit multiplexer.
// Latency: combinational, zero cycles.
// Backpressure: none (pure datapath).
//
// Ports:
//   i_sel - select, 0 picks i_d0, 1 picks i_d1
//   i_d0  - input 0 (N bits)
//   i_d1  - input 1 (N bits)
//   o_y   - selected output (N bits)
module mux2 #(
  parameter int N = 32
) (
  input  logic         i_sel,
  input  logic [N-1:0] i_d0,
  input  logic [N-1:0] i_d1,
  output logic [N-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/bus_demux2.sv
// Routes one upstream bus request to data memory (port 0) or MMIO (port 1) by address.
// Latency: request out 1 cycle after acceptance; response 1 cycle after target rvalid.
// Backpressure: one transaction outstanding; req_ready only in IDLE, target holds via mK_ready.
//
// Optional feature: define BUS_DEMUX2_TIMEOUT_EN to enable the WAIT-state timeout
// (error response after TIMEOUT cycles without rvalid). Default build: no timeout,
// rsp_err tied low, WAIT persists until the selected target answers.
//
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   req_valid/req_ready             - upstream request handshake
//   req_addr/we/be/wdata            - upstream request fields
//   rsp_valid/rsp_rdata/rsp_err     - one-cycle response pulse, held read data, timeout flag
//   mK_valid/mK_ready               - request handshake to target K (K = 0, 1)
//   mK_addr/we/be/wdata             - registered request copy (same on both targets)
//   mK_rvalid/mK_rdata              - response from target K (write ack included)
module bus_demux2
  import mips_bus_pkg::*;
#(
  parameter int          N         = 32,
  parameter logic [31:0] SEL_MASK  = SEL_MASK_DEFAULT,
  parameter logic [31:0] SEL_MATCH = SEL_MATCH_DEFAULT,
  parameter int          TIMEOUT   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  // upstream
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic         req_we,
  input  logic [3:0]   req_be,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err,
  // target 0 (data memory)
  output logic         m0_valid,
  input  logic         m0_ready,
  output logic [31:0]  m0_addr,
  output logic         m0_we,
  output logic [3:0]   m0_be,
  output logic [N-1:0] m0_wdata,
  input  logic         m0_rvalid,
  input  logic [N-1:0] m0_rdata,
  // target 1 (MMIO)
  output logic         m1_valid,
  input  logic         m1_ready,
  output logic [31:0]  m1_addr,
  output logic         m1_we,
  output logic [3:0]   m1_be,
  output logic [N-1:0] m1_wdata,
  input  logic         m1_rvalid,
  input  logic [N-1:0] m1_rdata
);

  state_t       r_state;
  state_t       w_state_nxt;

  logic [31:0]  r_addr;
  logic         r_we;
  logic [3:0]   r_be;
  logic [N-1:0] r_wdata;
  logic         r_sel;

  logic         r_rsp_valid;
  logic [N-1:0] r_rsp_rdata;

  logic         w_accept;
  logic         w_sel_ready;
  logic         w_sel_rvalid;
  logic         w_rsp_ok;
  logic         w_tmo;
  logic [N-1:0] w_sel_rdata;

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;

  // Only the selected target's handshake and response are ever observed.
  assign w_sel_ready  = r_sel ? m1_ready  : m0_ready;
  assign w_sel_rvalid = r_sel ? m1_rvalid : m0_rvalid;
  assign w_rsp_ok     = (r_state == ST_WAIT) && w_sel_rvalid;

  mux2 #(.N(N)) u_rdata_mux (
    .i_sel (r_sel),
    .i_d0  (m0_rdata),
    .i_d1  (m1_rdata),
    .o_y   (w_sel_rdata)
  );

`ifdef BUS_DEMUX2_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_rsp_err;

  // Counter sits at zero throughout REQ, so it starts from zero on WAIT entry.
  // Firing at TIMEOUT-1 puts the error pulse exactly TIMEOUT cycles after entry.
  assign w_tmo = (r_state == ST_WAIT) && !w_sel_rvalid &&
                 (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_tmo;
      if (r_state == ST_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

  assign rsp_err = r_rsp_err;
`else
  logic w_unused_tmo_cfg;

  assign w_unused_tmo_cfg = (TIMEOUT > 0);
  assign w_tmo            = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)            w_state_nxt = ST_REQ;
      ST_REQ:  if (w_sel_ready)         w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_rsp_ok || w_tmo)   w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are captured only on acceptance, so they are frozen
  // through REQ and WAIT regardless of what upstream drives meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_sel   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= req_addr;
      r_we    <= req_we;
      r_be    <= req_be;
      r_wdata <= req_wdata;
      r_sel   <= addr_is_mmio(req_addr, SEL_MASK, SEL_MATCH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rsp_ok || w_tmo;
      if (w_rsp_ok) begin
        r_rsp_rdata <= w_sel_rdata;
      end else if (w_tmo) begin
        r_rsp_rdata <= '0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  // Only valid is steered; both targets see the same registered request.
  assign m0_valid = (r_state == ST_REQ) && !r_sel;
  assign m1_valid = (r_state == ST_REQ) &&  r_sel;

  assign m0_addr  = r_addr;
  assign m0_we    = r_we;
  assign m0_be    = r_be;
  assign m0_wdata = r_wdata;
  assign m1_addr  = r_addr;
  assign m1_we    = r_we;
  assign m1_be    = r_be;
  assign m1_wdata = r_wdata;

endmodule
